// File: rtl/arith_pkg.sv
// Shared arithmetic-library definitions: FSM state encoding and a width helper.
package arith_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Ceiling log2; returns 0 for v <= 1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/full_sub.sv
// 1-bit full subtractor built from two half-subtractor stages and an OR.
module full_sub (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);

  logic d1, b1, b2;

  assign d1   = a ^ b;
  assign b1   = ~a & b;
  assign diff = d1 ^ bin;
  assign b2   = ~d1 & bin;
  assign bout = b1 | b2;

endmodule

// File: rtl/serial_sub.sv
// Digit-serial subtractor: a - b - bin over WIDTH bits, DIGIT bits per clock,
// LSB first, with start/busy/done handshake and registered result flags.
module serial_sub
  import arith_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (clog2(N) < 1) ? 1 : int'(clog2(N));

  state_t           state, nstate;
  logic [WIDTH-1:0] ra, rb, rd;
  logic [WIDTH-1:0] na, nb, nd;
  logic [DIGIT-1:0] dd;
  logic [DIGIT:0]   bc;
  logic             br;
  logic [CW-1:0]    cnt;
  logic             accept, last;

  assign accept = (state == IDLE) && start;
  assign last   = (state == RUN) && (cnt == CW'(N - 1));
  assign busy   = (state == RUN);
  assign diff   = rd;

  // Borrow ripples through DIGIT chained full subtractors.
  assign bc[0] = br;
  for (genvar i = 0; i < DIGIT; i++) begin : g_slice
    full_sub u_fs (
      .a    (ra[i]),
      .b    (rb[i]),
      .bin  (bc[i]),
      .diff (dd[i]),
      .bout (bc[i+1])
    );
  end

  // Separate full-width case avoids an empty slice when one digit covers the word.
  if (DIGIT < WIDTH) begin : g_shift
    assign na = {{DIGIT{1'b0}}, ra[WIDTH-1:DIGIT]};
    assign nb = {{DIGIT{1'b0}}, rb[WIDTH-1:DIGIT]};
    assign nd = {dd, rd[WIDTH-1:DIGIT]};
  end else begin : g_full
    assign na = '0;
    assign nb = '0;
    assign nd = dd;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nstate;
  end

  always_comb begin
    nstate = state;
    case (state)
      IDLE:    if (start) nstate = RUN;
      RUN:     if (last)  nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ra   <= '0;
      rb   <= '0;
      rd   <= '0;
      br   <= 1'b0;
      cnt  <= '0;
      done <= 1'b0;
      bout <= 1'b0;
      zero <= 1'b0;
    end else begin
      done <= last;
      if (accept) begin
        ra  <= a;
        rb  <= b;
        br  <= bin;
        cnt <= '0;
      end else if (state == RUN) begin
        ra  <= na;
        rb  <= nb;
        rd  <= nd;
        br  <= bc[DIGIT];
        cnt <= cnt + 1'b1;
        if (last) begin
          bout <= bc[DIGIT];
          zero <= (nd == '0);
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_sub.sv
// Directed self-checking bench for serial_sub (8/1, 16/4 and 16/16 configurations).
module tb_serial_sub;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  always #5 clk = ~clk;

  logic        start8 = 1'b0, bin8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy8, done8, bout8, zero8;
  logic [7:0]  diff8;

  logic        start16 = 1'b0, bin16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        busy4, done4, bout4, zero4;
  logic [15:0] diff4;
  logic        busyw, donew, boutw, zerow;
  logic [15:0] diffw;

  int errors = 0;
  int checks = 0;

  serial_sub #(.WIDTH(8), .DIGIT(1)) u_w8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .bin(bin8),
    .busy(busy8), .done(done8), .diff(diff8), .bout(bout8), .zero(zero8)
  );

  serial_sub #(.WIDTH(16), .DIGIT(4)) u_w16d4 (
    .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16), .bin(bin16),
    .busy(busy4), .done(done4), .diff(diff4), .bout(bout4), .zero(zero4)
  );

  serial_sub #(.WIDTH(16), .DIGIT(16)) u_w16d16 (
    .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16), .bin(bin16),
    .busy(busyw), .done(donew), .diff(diffw), .bout(boutw), .zero(zerow)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic launch8(input logic [7:0] av, input logic [7:0] bv, input logic bi);
    a8 = av; b8 = bv; bin8 = bi; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
  endtask

  // lat counts edges since the accepting edge; done must appear at lat == 8.
  task automatic wait8(input string tag, input int lat0,
                       input logic [7:0] ed, input logic eb, input logic ez);
    int lat, bsy;
    lat = lat0;
    bsy = lat0;
    while (!done8 && lat < 40) begin
      if (busy8) bsy++;
      @(negedge clk);
      lat++;
    end
    check({tag, "_done"}, done8, 1);
    check({tag, "_lat"}, lat, 8);
    check({tag, "_busycyc"}, bsy, 8);
    check({tag, "_busy_at_done"}, busy8, 0);
    check({tag, "_diff"}, diff8, ed);
    check({tag, "_bout"}, bout8, eb);
    check({tag, "_zero"}, zero8, ez);
  endtask

  task automatic run16(input string tag, input logic [15:0] av, input logic [15:0] bv,
                       input logic bi, input logic [15:0] ed, input logic eb);
    int lat, l4, lw;
    a16 = av; b16 = bv; bin16 = bi; start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    lat = 0; l4 = -1; lw = -1;
    while ((l4 < 0 || lw < 0) && lat < 40) begin
      if (done4 && l4 < 0) l4 = lat;
      if (donew && lw < 0) lw = lat;
      @(negedge clk);
      lat++;
    end
    check({tag, "_d4_lat"}, l4, 4);
    check({tag, "_d16_lat"}, lw, 1);
    check({tag, "_d4_diff"}, diff4, ed);
    check({tag, "_d4_bout"}, bout4, eb);
    check({tag, "_d16_diff"}, diffw, ed);
    check({tag, "_d16_bout"}, boutw, eb);
  endtask

  initial begin
    int extra;

    @(negedge clk);
    @(negedge clk);
    check("rst_busy", busy8, 0);
    check("rst_done", done8, 0);
    check("rst_diff", diff8, 0);
    check("rst_bout", bout8, 0);
    check("rst_zero", zero8, 0);
    check("rst_diff16", diff4, 0);
    rst = 1'b0;
    @(negedge clk);

    launch8(8'h5A, 8'h23, 1'b0);
    check("basic_busy_early", busy8, 1);
    wait8("basic", 0, 8'h37, 1'b0, 1'b0);

    launch8(8'h10, 8'h20, 1'b0);
    wait8("under", 0, 8'hF0, 1'b1, 1'b0);

    launch8(8'h00, 8'h00, 1'b1);
    wait8("binonly", 0, 8'hFF, 1'b1, 1'b0);

    launch8(8'h77, 8'h77, 1'b0);
    wait8("zero", 0, 8'h00, 1'b0, 1'b1);
    // start raised in the done cycle
    launch8(8'h01, 8'h00, 1'b0);
    wait8("b2b", 0, 8'h01, 1'b0, 1'b0);

    run16("w16a", 16'h1234, 16'h0FFF, 1'b0, 16'h0235, 1'b0);
    run16("w16b", 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1);

    launch8(8'h00, 8'hFF, 1'b1);
    wait8("wrapzero", 0, 8'h00, 1'b1, 1'b1);

    // second start mid-run must be ignored
    launch8(8'h5A, 8'h23, 1'b0);
    @(negedge clk);
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'h01; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    wait8("ignore", 3, 8'h37, 1'b0, 1'b0);
    extra = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done8) extra++;
    end
    check("ignore_extra_done", extra, 0);
    check("ignore_idle", busy8, 0);

    // prime bout/zero to 1 so the reset clear is observable
    launch8(8'h00, 8'hFF, 1'b1);
    wait8("prime", 0, 8'h00, 1'b1, 1'b1);
    launch8(8'h5A, 8'h23, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("mrst_busy", busy8, 0);
    check("mrst_done", done8, 0);
    check("mrst_diff", diff8, 0);
    check("mrst_bout", bout8, 0);
    check("mrst_zero", zero8, 0);
    @(negedge clk);
    rst = 1'b0;
    extra = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done8 || busy8) extra++;
    end
    check("mrst_quiet", extra, 0);
    launch8(8'h80, 8'h01, 1'b0);
    wait8("post_rst", 0, 8'h7F, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_sub.md
# serial_sub

Parametrised multi-cycle subtractor computing `a - b - bin` over `WIDTH` bits, processing `DIGIT` bits per clock from the LSB upward, with a registered borrow carried between digits. It follows the single-bit half subtractor as the general subtraction datapath of the arithmetic library. It trades latency for area and gives a start/busy/done handshake, borrow-in chaining and result flags.

## Interface
- `WIDTH`, default 8: operand and result width; must be ≥ 1 and an integer multiple of `DIGIT`.
- `DIGIT`, default 1: bits processed per cycle; the range is 1..`WIDTH`.
- `clk` in, 1: single clock, rising edge.
- `rst` in, 1: reset, asynchronous and active-high.
- `start` in, 1: request; sampled only when `busy`=0.
- `a` in, `WIDTH`: minuend; captured on an accepted start.
- `b` in, `WIDTH`: subtrahend; captured on an accepted start.
- `bin` in, 1: borrow-in; captured on an accepted start.
- `busy` out, 1: an operation is in progress.
- `done` out, 1: one-cycle pulse; the result is valid.
- `diff` out, `WIDTH`: `(a - b - bin) mod 2^WIDTH`.
- `bout` out, 1: final borrow. It is 1 when `a < b + bin` unsigned.
- `zero` out, 1: 1 when `diff == 0`.

## Operation
- Uses a two-state FSM, IDLE and RUN, and a digit counter `cnt` of width `clog2(WIDTH/DIGIT)` (at least 1).
- **IDLE:** a `start`=1 is accepted. On acceptance:
  - `a` and `b` load into the operand shift registers.
  - The borrow register loads `bin`.
  - `cnt` clears to 0 and the FSM moves to RUN.
- **RUN:** each cycle performs the following:
  - Subtract the low `DIGIT` bits of the operand registers using the borrow register. Ripple the borrow across the digit bits.
  - Shift the digit result into the MSB end of the result shift register. Shift both operand registers right by `DIGIT`.
  - Update the borrow register with the digit's borrow-out and increment `cnt`.
- **Last digit:** the RUN cycle with `cnt == WIDTH/DIGIT-1` processes the last digit. At that edge:
  - `diff` and `bout` take their final values, and `zero` is registered from the final `diff`.
  - `done` is set for one cycle and the FSM returns to IDLE.
- **Result hold:** `diff`, `bout` and `zero` hold their values until the next accepted start. During RUN, `diff` shows partial shift contents, and consumers must ignore them. `bout` and `zero` are not updated during RUN.
- **start while `busy`=1:** ignored; there is no queueing.
- **start in the same cycle `done`=1:** accepted, because the FSM is already in IDLE. This gives back-to-back operation with no bubble.
- **`DIGIT == WIDTH`:** the operation completes in one RUN cycle.
- **Chaining:** `bout` of a low-word instance may drive `bin` of a high-word instance started after the low word's `done`.
- **`rst` asserted at any time, including mid-RUN:**
  - The FSM goes to IDLE immediately.
  - All outputs clear: `busy`=0, `done`=0, `diff`=0, `bout`=0, `zero`=0.
  - The operation in progress is discarded.

## Timing
- With an accepted start at edge k:
  - `busy`=1 from edge k through edge k+N, where N = `WIDTH/DIGIT`.
  - `busy`=0 and `done`=1 during the cycle after edge k+N.
- Latency from the start edge to `done` is N cycles. Throughput is one operation per N cycles.
- `done` is high for exactly one cycle per operation.
- All outputs are registered and there is no combinational input-to-output path.
- The critical path is a `DIGIT`-bit borrow ripple plus the register setup.

## Structure
- Shared package `arith_pkg` holds the FSM state encoding (IDLE=1'b0, RUN=1'b1) and the width helper `clog2`.
- Sub-module `full_sub` computes a 1-bit difference and borrow-out from `a`, `b` and borrow-in. It is built from two half-subtractor stages and an OR.
- A generate loop chains `DIGIT` instances of `full_sub` to form the digit slice.
- The FSM, counter and shift registers live in `serial_sub`.

## Test plan
- Basic subtract, with `WIDTH`=8, `DIGIT`=1:
  - Stimulus: `a`=0x5A, `b`=0x23, `bin`=0, start pulse.
  - Response: `done` 8 cycles after the start edge; `diff`=0x37, `bout`=0, `zero`=0; `busy` high for exactly 8 cycles.
- Underflow and borrow-in:
  - `a`=0x10, `b`=0x20, `bin`=0 → `diff`=0xF0, `bout`=1.
  - `a`=0x00, `b`=0x00, `bin`=1 → `diff`=0xFF, `bout`=1.
- Zero flag and back-to-back:
  - `a`=`b`=0x77, `bin`=0 → `diff`=0x00, `zero`=1.
  - A new start (`a`=0x01, `b`=0x00) asserted in the `done` cycle is accepted. Its `done` follows 8 cycles later with `diff`=0x01 and `zero`=0.
- Digit-serial mode, `WIDTH`=16, `DIGIT`=4:
  - `a`=0x1234, `b`=0x0FFF → `diff`=0x0235, `bout`=0.
  - `done` arrives 4 cycles after start.
  - With `DIGIT`=16, `done` arrives 1 cycle after start.
- Start while busy:
  - A second start with different operands, asserted mid-RUN, is ignored.
  - The result equals the first operation's, and there is only one `done` pulse.
- Reset mid-operation:
  - `rst` asserted at cycle 3 of 8 clears all outputs and returns the FSM to IDLE with no `done` pulse.
  - A start after release (`a`=0x80, `b`=0x01) gives `diff`=0x7F, `bout`=0.
